// File: rtl/sram_responder_pkg.sv
// rtl/sram_responder_pkg.sv - shared state encoding, widths and active-low levels for the SRAM responder
package sram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITE_ARMED = 2'd1,
    READ_DELAY  = 2'd2,
    READ_DRIVE  = 2'd3
  } sram_state_e;

  localparam int DATA_WIDTH     = 16;
  localparam int BUS_ADDR_WIDTH = 24;
  localparam int DELAY_WIDTH    = 8;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // Lane enables are active-low; a disabled lane reads back as zero.
  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic lb_n, input logic ub_n,
                                                      input logic [DATA_WIDTH-1:0] d);
    return {(ub_n == HIGH) ? 8'h00 : d[15:8], (lb_n == HIGH) ? 8'h00 : d[7:0]};
  endfunction

endpackage

// File: rtl/sram_delay_counter.sv
// rtl/sram_delay_counter.sv - loadable down-counter that flags zero, used to pace the read access delay
module sram_delay_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - async-SRAM device model on the pin interface; SRAM_RESPONDER_PROTOCOL_CHECK_EN adds protocolError
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH                 = 10,
  parameter int CLOCK_TICKS_FOR_READ_DELAY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BUS_ADDR_WIDTH-1:0] addrIn,
  inout  wire  [DATA_WIDTH-1:0]     dataBus,
  input  logic                      chipEnable,
  input  logic                      outputEnable,
  input  logic                      writeEnable,
  input  logic                      lowerByte,
  input  logic                      upperByte,
  output logic                      dataDriveEn,
  output logic                      readValid
`ifdef SRAM_RESPONDER_PROTOCOL_CHECK_EN
  ,
  output logic                      protocolError
`endif
);

  // Counter runs from D-1 down to zero so READ_DELAY lasts exactly D cycles.
  localparam logic [DELAY_WIDTH-1:0] DELAY_LOAD = DELAY_WIDTH'(CLOCK_TICKS_FOR_READ_DELAY - 1);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

  logic                  ce_q, oe_q, we_q, lb_q, ub_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_lb_q, wr_lb_d, wr_ub_q, wr_ub_d;
  logic                  drive_q, drive_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic write_req, read_req, commit, cnt_load, cnt_en, cnt_zero;
  logic unused_addr_bits;

  assign unused_addr_bits = ^addrIn[BUS_ADDR_WIDTH-1:ADDR_WIDTH];

  sram_delay_counter #(.WIDTH(DELAY_WIDTH)) u_delay (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (DELAY_LOAD),
    .enable     (cnt_en),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_lb_d   = wr_lb_q;
    wr_ub_d   = wr_ub_q;
    drive_d   = LOW;
    rdata_d   = rdata_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    commit    = 1'b0;
    write_req = (ce_q == LOW) && (we_q == LOW);
    read_req  = (ce_q == LOW) && (oe_q == LOW) && (we_q == HIGH);
    unique case (state_q)
      IDLE: begin
        if (write_req) begin
          state_d = WRITE_ARMED;
        end else if (read_req) begin
          state_d  = READ_DELAY;
          cnt_load = 1'b1;
        end
      end
      WRITE_ARMED: begin
        if (!write_req) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      READ_DELAY: begin
        cnt_en = 1'b1;
        if (write_req) begin
          state_d = WRITE_ARMED;
        end else if (!read_req) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          state_d = READ_DRIVE;
          drive_d = HIGH;
          rdata_d = lane_mask(lb_q, ub_q, mem[addr_q]);
        end
      end
      READ_DRIVE: begin
        if (write_req) begin
          state_d = WRITE_ARMED;
        end else if (!read_req) begin
          state_d = IDLE;
        end else begin
          drive_d = HIGH;
          rdata_d = lane_mask(lb_q, ub_q, mem[addr_q]);
        end
      end
      default: state_d = IDLE;
    endcase
    // The last armed cycle wins: its address, data and lanes are what commit.
    if (state_d == WRITE_ARMED) begin
      wr_addr_d = addr_q;
      wr_data_d = din_q;
      wr_lb_d   = lb_q;
      wr_ub_d   = ub_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q      <= HIGH;
      oe_q      <= HIGH;
      we_q      <= HIGH;
      lb_q      <= HIGH;
      ub_q      <= HIGH;
      addr_q    <= '0;
      din_q     <= '0;
      state_q   <= IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_lb_q   <= HIGH;
      wr_ub_q   <= HIGH;
      drive_q   <= LOW;
      rdata_q   <= '0;
    end else begin
      ce_q      <= chipEnable;
      oe_q      <= outputEnable;
      we_q      <= writeEnable;
      lb_q      <= lowerByte;
      ub_q      <= upperByte;
      addr_q    <= addrIn[ADDR_WIDTH-1:0];
      din_q     <= dataBus;
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_lb_q   <= wr_lb_d;
      wr_ub_q   <= wr_ub_d;
      drive_q   <= drive_d;
      rdata_q   <= rdata_d;
    end
  end

  // Memory contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (commit && !rst) begin
      if (wr_lb_q == LOW) mem[wr_addr_q][7:0]  <= wr_data_q[7:0];
      if (wr_ub_q == LOW) mem[wr_addr_q][15:8] <= wr_data_q[15:8];
    end
  end

  assign dataBus     = drive_q ? rdata_q : {DATA_WIDTH{1'bz}};
  assign dataDriveEn = drive_q;
  assign readValid   = drive_q;

`ifdef SRAM_RESPONDER_PROTOCOL_CHECK_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = perr_q;
    if ((ce_q == LOW) && (we_q == LOW) && (oe_q == LOW)) perr_d = 1'b1;
    if ((state_q == WRITE_ARMED) && write_req &&
        ((addr_q != wr_addr_q) || (lb_q != wr_lb_q) || (ub_q != wr_ub_q))) perr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end

  assign protocolError = perr_q;
`endif

endmodule
